// File: rtl/cpu_clk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_clk_pkg
//  Purpose  : Shared speed codes, FSM state encoding and period/high-time
//             lookup helpers for the CPU clock scheduler.
//  Contents : SPD_* speed codes, state_t, per_of(), hi_of(), norm_speed(),
//             PCLK_HALF.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_clk_pkg;

  // Speed codes (code 2'b11 is folded onto SPD_477 by norm_speed)
  localparam logic [1:0] SPD_477  = 2'b00;
  localparam logic [1:0] SPD_716  = 2'b01;
  localparam logic [1:0] SPD_1432 = 2'b10;

  // Peripheral clock half period in clk_vga cycles (28.636 MHz / 12)
  localparam int PCLK_HALF = 6;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_WAIT_SAFE = 2'd1,
    ST_WAIT_EDGE = 2'd2
  } state_t;

  // CPU clock period in clk_vga cycles for a (normalised) speed code
  function automatic logic [2:0] per_of(input logic [1:0] code);
    case (code)
      SPD_716:  per_of = 3'd4;
      SPD_1432: per_of = 3'd2;
      default:  per_of = 3'd6;
    endcase
  endfunction

  // CPU clock high time in clk_vga cycles for a (normalised) speed code
  function automatic logic [1:0] hi_of(input logic [1:0] code);
    case (code)
      SPD_1432: hi_of = 2'd1;
      default:  hi_of = 2'd2;
    endcase
  endfunction

  // Unused code 2'b11 behaves as the slowest speed
  function automatic logic [1:0] norm_speed(input logic [1:0] code);
    norm_speed = (code == 2'b11) ? SPD_477 : code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Single-bit two-flop synchroniser with asynchronous reset to 0.
//  Ports    : clk_vga    - destination clock
//             reset_wire - asynchronous active-high reset
//             din        - asynchronous input
//             dout       - synchronised output (two clk_vga cycles latency)
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk_vga,
  input  logic reset_wire,
  input  logic din,
  output logic dout
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_vga or posedge reset_wire) begin
    if (reset_wire) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= din;
      r_sync <= r_meta;
    end
  end

  assign dout = r_sync;

endmodule
`default_nettype wire

// File: rtl/cpu_clock_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_clock_scheduler
//  Purpose  : Generates the CPU clock (4.77 / 7.16 / 14.318 MHz) and the
//             2.385 MHz peripheral clock from clk_vga. CPU speed changes are
//             deferred to a bus-idle point (biu_done, or a timeout) and then
//             to the end of the current CPU clock period, so no runt phase is
//             ever produced.
//  Ports    : clk_vga, reset_wire (async, active-high)
//             speed_req[1:0]  requested speed code (level)
//             biu_done        CPU bus idle (foreign domain, synchronised here)
//             cpu_clk, cpu_rise     CPU clock level / first-high-cycle pulse
//             pclk, pclk_rise       peripheral clock level / rise pulse
//             speed_cur[1:0]  speed code currently driving cpu_clk
//             busy            a speed switch is pending
//             timeout_flag    pulse: switch forced by timeout
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_clock_scheduler
  import cpu_clk_pkg::*;
#(
  parameter logic [1:0] RESET_SPEED  = 2'b00,
  parameter int         SAFE_TIMEOUT = 4096,
  parameter int         TMO_W        = 13
) (
  input  logic       clk_vga,
  input  logic       reset_wire,
  input  logic [1:0] speed_req,
  input  logic       biu_done,
  output logic       cpu_clk,
  output logic       cpu_rise,
  output logic       pclk,
  output logic       pclk_rise,
  output logic [1:0] speed_cur,
  output logic       busy,
  output logic       timeout_flag
);

  localparam logic [TMO_W-1:0] c_TMO_LAST  = TMO_W'(SAFE_TIMEOUT - 1);
  localparam logic [3:0]       c_PCLK_LAST = 4'(2 * PCLK_HALF - 1);
  localparam logic [3:0]       c_PCLK_HALF = 4'(PCLK_HALF);

  // --------------------------------------------------------------------------
  // biu_done synchroniser
  // --------------------------------------------------------------------------
  logic w_bd_s;

  sync_2ff u_sync_bd (
    .clk_vga    (clk_vga),
    .reset_wire (reset_wire),
    .din        (biu_done),
    .dout       (w_bd_s)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_speed_cur;
  logic [1:0]       r_pend;
  logic [1:0]       w_pend_next;
  logic [TMO_W-1:0] r_tmo;
  logic [TMO_W-1:0] w_tmo_next;
  logic             w_tmo_fire;
  logic             w_switch;
  logic [1:0]       w_req;

  // r_ph is the phase cpu_clk will show in the cycle after the next edge;
  // cpu_clk/cpu_rise are decoded from it one register stage later. Holding
  // the "upcoming" phase lets reset (r_ph = 0) produce a full first high
  // phase together with cpu_rise.
  logic [2:0]       r_ph;
  logic [2:0]       w_per_cur;
  logic [1:0]       w_hi_cur;
  logic             w_ph_last;

  logic [3:0]       r_pcnt;

  assign w_req     = norm_speed(speed_req);
  assign w_per_cur = per_of(r_speed_cur);
  assign w_hi_cur  = hi_of(r_speed_cur);
  assign w_ph_last = (r_ph == (w_per_cur - 3'd1));

  // --------------------------------------------------------------------------
  // Switch scheduler: next state / pending speed / timeout counter
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_pend_next  = r_pend;
    w_tmo_next   = r_tmo;
    w_tmo_fire   = 1'b0;
    w_switch     = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (w_req != r_speed_cur) begin
          w_pend_next  = w_req;
          w_tmo_next   = '0;
          w_state_next = ST_WAIT_SAFE;
        end
      end

      ST_WAIT_SAFE: begin
        // Track the request until the bus-idle point is reached
        w_pend_next = w_req;
        if (w_req == r_speed_cur) begin
          w_state_next = ST_RUN;
        end else if (w_bd_s) begin
          w_state_next = ST_WAIT_EDGE;
        end else if (r_tmo == c_TMO_LAST) begin
          w_tmo_fire   = 1'b1;
          w_state_next = ST_WAIT_EDGE;
        end else begin
          w_tmo_next = r_tmo + 1'b1;
        end
      end

      ST_WAIT_EDGE: begin
        // Upcoming cycle is the last low cycle of the old period: take the
        // new speed now so the following period starts fresh at phase 0.
        if (w_ph_last) begin
          w_switch     = 1'b1;
          w_state_next = ST_RUN;
        end
      end

      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_vga or posedge reset_wire) begin
    if (reset_wire) begin
      r_state      <= ST_RUN;
      r_pend       <= RESET_SPEED;
      r_tmo        <= '0;
      r_speed_cur  <= RESET_SPEED;
      busy         <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pend       <= w_pend_next;
      r_tmo        <= w_tmo_next;
      busy         <= (w_state_next != ST_RUN);
      timeout_flag <= w_tmo_fire;
      if (w_switch) begin
        r_speed_cur <= r_pend;
      end
    end
  end

  assign speed_cur = r_speed_cur;

  // --------------------------------------------------------------------------
  // CPU clock generator. A switch only happens on the wrap, so the phase
  // wraps to 0 identically with or without a switch.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_vga or posedge reset_wire) begin
    if (reset_wire) begin
      r_ph     <= 3'd0;
      cpu_clk  <= 1'b0;
      cpu_rise <= 1'b0;
    end else begin
      r_ph     <= w_ph_last ? 3'd0 : (r_ph + 3'd1);
      cpu_clk  <= (r_ph < {1'b0, w_hi_cur});
      cpu_rise <= (r_ph == 3'd0);
    end
  end

  // --------------------------------------------------------------------------
  // Peripheral clock: free-running divide-by-12, independent of CPU speed
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_vga or posedge reset_wire) begin
    if (reset_wire) begin
      r_pcnt    <= 4'd0;
      pclk      <= 1'b0;
      pclk_rise <= 1'b0;
    end else begin
      r_pcnt    <= (r_pcnt == c_PCLK_LAST) ? 4'd0 : (r_pcnt + 4'd1);
      pclk      <= (r_pcnt < c_PCLK_HALF);
      pclk_rise <= (r_pcnt == 4'd0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_clock_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_cpu_clock_scheduler
//  Purpose  : Scoreboard bench for cpu_clock_scheduler. A waveform-queue
//             reference model pushes the expected outputs for every clk_vga
//             cycle; a monitor pops and compares them on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_clock_scheduler;

  localparam int SAFE_TIMEOUT = 4096;

  logic       clk_vga    = 1'b0;
  logic       reset_wire = 1'b1;
  logic [1:0] speed_req  = 2'b00;
  logic       biu_done   = 1'b0;
  logic       cpu_clk, cpu_rise, pclk, pclk_rise, busy, timeout_flag;
  logic [1:0] speed_cur;

  cpu_clock_scheduler #(
    .RESET_SPEED  (2'b00),
    .SAFE_TIMEOUT (SAFE_TIMEOUT),
    .TMO_W        (13)
  ) dut (
    .clk_vga      (clk_vga),
    .reset_wire   (reset_wire),
    .speed_req    (speed_req),
    .biu_done     (biu_done),
    .cpu_clk      (cpu_clk),
    .cpu_rise     (cpu_rise),
    .pclk         (pclk),
    .pclk_rise    (pclk_rise),
    .speed_cur    (speed_cur),
    .busy         (busy),
    .timeout_flag (timeout_flag)
  );

  always #5 clk_vga = ~clk_vga;

  typedef struct packed {
    logic       cpu_clk;
    logic       cpu_rise;
    logic       pclk;
    logic       pclk_rise;
    logic [1:0] speed_cur;
    logic       busy;
    logic       timeout_flag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   dut_to_count = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, req, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: the CPU clock is a queue of upcoming levels, refilled one
  // whole period at a time with the speed in force when the period starts.
  // Encoding: 3 = first high cycle, 1 = high, 0 = low.
  // --------------------------------------------------------------------------
  int m_cur, m_pend, m_mode, m_cnt, m_edges;   // m_mode: 0 idle, 1 await idle, 2 await boundary
  int wave[$];
  bit m_bd1, m_bd2;

  function automatic int per(input int s);
    return (s == 1) ? 4 : ((s == 2) ? 2 : 6);
  endfunction

  function automatic int hi(input int s);
    return (s == 2) ? 1 : 2;
  endfunction

  function automatic int norm(input logic [1:0] c);
    return (c == 2'b11) ? 0 : int'(c);
  endfunction

  task automatic model_reset();
    m_cur = 0; m_pend = 0; m_mode = 0; m_cnt = 0; m_edges = 0;
    wave.delete();
    m_bd1 = 1'b0; m_bd2 = 1'b0;
  endtask

  initial model_reset();

  always @(posedge clk_vga) begin
    if (reset_wire) begin
      model_reset();
    end else begin
      exp_t e;
      int   req, v;
      bit   to;
      req = norm(speed_req);
      to  = 1'b0;
      if (wave.size() == 0)
        for (int i = 0; i < per(m_cur); i++)
          wave.push_back((i == 0) ? 3 : ((i < hi(m_cur)) ? 1 : 0));
      case (m_mode)
        0: if (req != m_cur) begin m_pend = req; m_cnt = 0; m_mode = 1; end
        1: begin
          m_pend = req;
          if (req == m_cur)                  m_mode = 0;
          else if (m_bd2)                    m_mode = 2;
          else if (m_cnt == SAFE_TIMEOUT - 1) begin to = 1'b1; m_mode = 2; end
          else                               m_cnt++;
        end
        default: if (wave.size() == 1) begin m_cur = m_pend; m_mode = 0; end
      endcase
      v = wave.pop_front();
      m_bd2 = m_bd1;
      m_bd1 = biu_done;
      m_edges++;
      e.cpu_clk      = (v != 0);
      e.cpu_rise     = (v == 3);
      e.pclk         = (((m_edges - 1) % 12) < 6);
      e.pclk_rise    = (((m_edges - 1) % 12) == 0);
      e.speed_cur    = 2'(m_cur);
      e.busy         = (m_mode != 0);
      e.timeout_flag = to;
      exp_q.push_back(e);
    end
  end

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  task automatic chk_reset_values(input string tag);
    chk({tag, "_cpu_clk"},      int'(cpu_clk),      0);
    chk({tag, "_cpu_rise"},     int'(cpu_rise),     0);
    chk({tag, "_pclk"},         int'(pclk),         0);
    chk({tag, "_pclk_rise"},    int'(pclk_rise),    0);
    chk({tag, "_speed_cur"},    int'(speed_cur),    0);
    chk({tag, "_busy"},         int'(busy),         0);
    chk({tag, "_timeout_flag"}, int'(timeout_flag), 0);
  endtask

  always @(negedge clk_vga) begin
    if (reset_wire) begin
      chk_reset_values("rst");
    end else if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (timeout_flag) dut_to_count++;
      chk("cpu_clk",      int'(cpu_clk),      int'(e.cpu_clk));
      chk("cpu_rise",     int'(cpu_rise),     int'(e.cpu_rise));
      chk("pclk",         int'(pclk),         int'(e.pclk));
      chk("pclk_rise",    int'(pclk_rise),    int'(e.pclk_rise));
      chk("speed_cur",    int'(speed_cur),    int'(e.speed_cur));
      chk("busy",         int'(busy),         int'(e.busy));
      chk("timeout_flag", int'(timeout_flag), int'(e.timeout_flag));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_vga);
  endtask

  task automatic pulse_bd(input int len);
    biu_done = 1'b1;
    cyc(len);
    biu_done = 1'b0;
  endtask

  // Assert reset between edges, check outputs before any edge arrives
  task automatic async_reset(input int hold);
    @(posedge clk_vga);
    #2;
    reset_wire = 1'b1;
    exp_q.delete();
    #1;
    chk_reset_values("async_rst");
    repeat (hold) @(posedge clk_vga);
    #2;
    reset_wire = 1'b0;
  endtask

  initial begin
    int to_before;

    // Power-up reset
    cyc(3);
    @(posedge clk_vga);
    #2;
    reset_wire = 1'b0;
    cyc(30);

    // 00 -> 10 with biu_done pulse 20 cycles later
    speed_req = 2'b10;
    cyc(20);
    pulse_bd(3);
    cyc(20);

    // 10 -> 01 via biu_done, then 01 -> 00 forced by timeout
    speed_req = 2'b01;
    cyc(5);
    pulse_bd(3);
    cyc(20);
    to_before = dut_to_count;
    speed_req = 2'b00;
    cyc(SAFE_TIMEOUT + 30);
    chk("timeout_pulses", dut_to_count - to_before, 1);

    // Abort: 00 -> 01 -> 00 before the bus goes idle
    speed_req = 2'b01;
    cyc(10);
    speed_req = 2'b00;
    cyc(20);

    // Code 11 from speed 00 starts nothing
    speed_req = 2'b11;
    cyc(20);
    speed_req = 2'b00;
    cyc(5);

    // Reset asserted while waiting for the period boundary
    speed_req = 2'b10;
    biu_done  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (m_mode == 2 && wave.size() >= 2) break;
    end
    async_reset(3);
    speed_req = 2'b00;
    biu_done  = 1'b0;
    cyc(20);

    // Randomised switching with short, long and stuck biu_done
    for (int it = 0; it < 250; it++) begin
      speed_req = 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 15));
      if ($urandom_range(0, 9) != 0) pulse_bd($urandom_range(1, 8));
      cyc($urandom_range(1, 25));
    end
    biu_done = 1'b1;
    cyc(3);
    pulse_bd(2);
    cyc(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
